// File: rtl/usb_hub_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: assembler FSM
// encoding and the width helpers used to size counters, levels and pointers.
package usb_hub_pkg;

  // Assembler state: IDLE holds no pending bits, ACCUM holds 1..DATA_WIDTH-1.
  typedef enum logic [0:0] {
    ASM_IDLE  = 1'b0,
    ASM_ACCUM = 1'b1
  } asm_state_e;

  // Width of a bit counter that must represent 0..dw inclusive.
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

  // Width of an occupancy level that must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a FIFO read/write pointer (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sipo_fifo_deser_sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is presented combinationally
// from storage whenever the FIFO is non-empty and reads as zero when empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo
  import usb_hub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int PW  = ptr_w(DEPTH);
  localparam int LVW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVW-1:0]   level_q, level_d;
  logic             empty_s, full_s;
  logic             do_push_s, do_pop_s;

  // Status flags and the effective push/pop qualifiers.
  always_comb begin
    empty_s   = (level_q == {LVW{1'b0}});
    full_s    = (level_q == LVW'(DEPTH));
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Next pointers and occupancy; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LVW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_d = level_q + LVW'(1);
        2'b01:   level_d = level_q - LVW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LVW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (!clr && do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Show-ahead head entry, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      rd_data = {WIDTH{1'b0}};
    end else begin
      rd_data = mem_q[rd_ptr_q];
    end
    empty = empty_s;
    full  = full_s;
    level = level_q;
  end

endmodule

// File: rtl/sipo_fifo_deser.sv
// Serial-in parallel-out deserializer. Valid serial bits are written by index
// into an accumulating word; complete words, or partial words closed by s_eop,
// are pushed with their bit count and last flag into a show-ahead FIFO.
// sipo_cancel aborts everything in one cycle; rst outranks cancel.
module sipo_fifo_deser
  import usb_hub_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_data_in,
  input  logic                             s_data_in_val,
  input  logic                             s_eop,
  input  logic                             sipo_cancel,
  output logic [DATA_WIDTH-1:0]            p_data_out,
  output logic                             p_data_out_val,
  input  logic                             p_data_out_rdy,
  output logic                             p_data_out_last,
  output logic [cnt_w(DATA_WIDTH)-1:0]     p_data_out_nbits,
  output logic                             overflow,
  output logic [lvl_w(DEPTH)-1:0]          fifo_level
);

  localparam int NBW = cnt_w(DATA_WIDTH);
  localparam int LVW = lvl_w(DEPTH);
  localparam int FW  = DATA_WIDTH + NBW + 1;

  asm_state_e            state_q, state_d;
  logic [NBW-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  ovf_q, ovf_d;

  logic [NBW-1:0]        pos_s;
  logic [NBW-1:0]        cnt_wr_s;
  logic [DATA_WIDTH-1:0] word_wr_s;
  logic                  word_full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [FW-1:0]         push_data_s;
  logic [FW-1:0]         head_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [LVW-1:0]        fifo_level_s;

  // Assembler FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ASM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Assembler FSM next state: a lone valid bit opens a word, any push closes it.
  always_comb begin
    state_d = state_q;
    if (sipo_cancel) begin
      state_d = ASM_IDLE;
    end else begin
      case (state_q)
        ASM_IDLE: begin
          if (s_data_in_val && !s_eop) begin
            state_d = ASM_ACCUM;
          end else begin
            state_d = ASM_IDLE;
          end
        end
        ASM_ACCUM: begin
          if (push_s) begin
            state_d = ASM_IDLE;
          end else begin
            state_d = ASM_ACCUM;
          end
        end
        default: state_d = ASM_IDLE;
      endcase
    end
  end

  // Assembler FSM outputs: indexed bit write and the push decision.
  always_comb begin
    if (LSB_FIRST != 0) begin
      pos_s = cnt_q;
    end else begin
      pos_s = NBW'(DATA_WIDTH - 1) - cnt_q;
    end
    word_wr_s = word_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s_data_in_val && (pos_s == NBW'(i))) begin
        word_wr_s[i] = s_data_in;
      end else begin
        word_wr_s[i] = word_q[i];
      end
    end
    cnt_wr_s    = cnt_q + NBW'(s_data_in_val);
    word_full_s = s_data_in_val && (cnt_q == NBW'(DATA_WIDTH - 1));
    push_s      = 1'b0;
    if (sipo_cancel) begin
      push_s = 1'b0;
    end else begin
      case (state_q)
        ASM_IDLE:  push_s = s_eop && s_data_in_val;
        ASM_ACCUM: push_s = word_full_s || s_eop;
        default:   push_s = 1'b0;
      endcase
    end
    push_data_s = {s_eop, cnt_wr_s, word_wr_s};
  end

  // Next bit count, partial word and sticky overflow.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    ovf_d  = ovf_q;
    if (sipo_cancel) begin
      cnt_d  = {NBW{1'b0}};
      word_d = {DATA_WIDTH{1'b0}};
      ovf_d  = 1'b0;
    end else begin
      if (push_s) begin
        cnt_d  = {NBW{1'b0}};
        word_d = {DATA_WIDTH{1'b0}};
      end else begin
        cnt_d  = cnt_wr_s;
        word_d = word_wr_s;
      end
      if (push_s && fifo_full_s && !pop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Bit count, partial word and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {NBW{1'b0}};
      word_q <= {DATA_WIDTH{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      ovf_q  <= ovf_d;
    end
  end

  // Pop only when the consumer is ready and a head word exists.
  always_comb begin
    pop_s = p_data_out_rdy && !fifo_empty_s;
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (sipo_cancel),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .rd_data   (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .level     (fifo_level_s)
  );

  // Unpack the head entry onto the output ports.
  always_comb begin
    p_data_out       = head_s[DATA_WIDTH-1:0];
    p_data_out_nbits = head_s[DATA_WIDTH +: NBW];
    p_data_out_last  = head_s[FW-1];
    p_data_out_val   = !fifo_empty_s;
    overflow         = ovf_q;
    fifo_level       = fifo_level_s;
  end

endmodule

// File: tb/tb_sipo_fifo_deser.sv
// Bench for sipo_fifo_deser: one LSB-first and one MSB-first instance share
// the same stimulus; a queue-based packet model predicts both every cycle.
module tb_sipo_fifo_deser;

  localparam int DW = 8;
  localparam int DP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, s_data_in, s_data_in_val, s_eop, sipo_cancel, p_data_out_rdy;

  logic [DW-1:0] a_data, b_data;
  logic          a_val, b_val, a_last, b_last, a_ovf, b_ovf;
  logic [3:0]    a_nbits, b_nbits;
  logic [2:0]    a_lvl, b_lvl;

  sipo_fifo_deser #(.DATA_WIDTH(DW), .DEPTH(DP), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .s_data_in(s_data_in), .s_data_in_val(s_data_in_val),
    .s_eop(s_eop), .sipo_cancel(sipo_cancel), .p_data_out(a_data),
    .p_data_out_val(a_val), .p_data_out_rdy(p_data_out_rdy),
    .p_data_out_last(a_last), .p_data_out_nbits(a_nbits),
    .overflow(a_ovf), .fifo_level(a_lvl)
  );

  sipo_fifo_deser #(.DATA_WIDTH(DW), .DEPTH(DP), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .s_data_in(s_data_in), .s_data_in_val(s_data_in_val),
    .s_eop(s_eop), .sipo_cancel(sipo_cancel), .p_data_out(b_data),
    .p_data_out_val(b_val), .p_data_out_rdy(p_data_out_rdy),
    .p_data_out_last(b_last), .p_data_out_nbits(b_nbits),
    .overflow(b_ovf), .fifo_level(b_lvl)
  );

  typedef struct {
    logic [DW-1:0] dl;
    logic [DW-1:0] dm;
    int            nb;
    logic          last;
  } ent_t;

  ent_t mq[$];
  bit   pend[$];
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: bits collect in a list, words close on width or eop.
  task automatic model_step();
    ent_t e;
    bit   pop;
    int   pre;
    if (rst || sipo_cancel) begin
      mq.delete();
      pend.delete();
      m_ovf = 1'b0;
      return;
    end
    pre = mq.size();
    pop = (pre > 0) && p_data_out_rdy;
    if (pop) void'(mq.pop_front());
    if (s_data_in_val) pend.push_back(s_data_in);
    if (pend.size() == DW || (s_eop && pend.size() > 0)) begin
      e.dl = '0;
      e.dm = '0;
      for (int i = 0; i < pend.size(); i++) begin
        e.dl[i]        = pend[i];
        e.dm[DW-1-i]   = pend[i];
      end
      e.nb   = pend.size();
      e.last = s_eop;
      pend.delete();
      if (pre == DP && !pop) m_ovf = 1'b1;
      else mq.push_back(e);
    end
  endtask

  task automatic check_all();
    ent_t h;
    bit   v;
    v = (mq.size() > 0);
    h.dl = '0; h.dm = '0; h.nb = 0; h.last = 1'b0;
    if (v) h = mq[0];
    chk("a_val",   64'(a_val),   64'(v));
    chk("b_val",   64'(b_val),   64'(v));
    chk("a_data",  64'(a_data),  64'(h.dl));
    chk("b_data",  64'(b_data),  64'(h.dm));
    chk("a_nbits", 64'(a_nbits), 64'(h.nb));
    chk("b_nbits", 64'(b_nbits), 64'(h.nb));
    chk("a_last",  64'(a_last),  64'(h.last));
    chk("b_last",  64'(b_last),  64'(h.last));
    chk("a_ovf",   64'(a_ovf),   64'(m_ovf));
    chk("b_ovf",   64'(b_ovf),   64'(m_ovf));
    chk("a_lvl",   64'(a_lvl),   64'(mq.size()));
    chk("b_lvl",   64'(b_lvl),   64'(mq.size()));
  endtask

  task automatic drive(input bit v, input bit b, input bit e, input bit c,
                       input bit r, input bit rs);
    s_data_in_val  = v;
    s_data_in      = b;
    s_eop          = e;
    sipo_cancel    = c;
    p_data_out_rdy = r;
    rst            = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send_rand_words(input int n, input bit r);
    for (int i = 0; i < n * DW; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, r, 1'b0);
  endtask

  logic [DW-1:0] pat;

  initial begin
    s_data_in = 1'b0; s_data_in_val = 1'b0; s_eop = 1'b0;
    sipo_cancel = 1'b0; p_data_out_rdy = 1'b0; rst = 1'b1;
    #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_val", 64'(a_val), 64'(0));
    chk("reset_lvl", 64'(a_lvl), 64'(0));

    // Known pattern 1,0,1,1,0,0,1,0 with rdy held high.
    pat = 8'b0100_1101;
    for (int i = 0; i < DW; i++) begin
      drive(1'b1, pat[i], 1'b0, 1'b0, 1'b1, 1'b0);
      if (i < DW - 1) chk("no_val_early", 64'(a_val), 64'(0));
    end
    chk("lsb_word",  64'(a_data),  64'(8'h4D));
    chk("msb_word",  64'(b_data),  64'(8'hB2));
    chk("full_nb",   64'(a_nbits), 64'(8));
    chk("full_last", 64'(a_last),  64'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Three-bit packet 1,1,0 with eop on the third bit.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("part_msb",  64'(b_data),  64'(8'hC0));
    chk("part_lsb",  64'(a_data),  64'(8'h03));
    chk("part_nb",   64'(b_nbits), 64'(3));
    chk("part_last", 64'(b_last),  64'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: five words with no reader, then drain.
    send_rand_words(5, 1'b0);
    chk("ovf_lvl",  64'(a_lvl), 64'(4));
    chk("ovf_flag", 64'(a_ovf), 64'(1));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_sticky", 64'(a_ovf), 64'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cancel_ovf", 64'(a_ovf), 64'(0));

    // Full FIFO with a pop on the cycle word five completes.
    send_rand_words(4, 1'b0);
    for (int i = 0; i < DW - 1; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_full_lvl", 64'(a_lvl), 64'(4));
    chk("pp_full_ovf", 64'(a_ovf), 64'(0));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Cancel with two queued words and four pending bits.
    send_rand_words(2, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cancel_val", 64'(a_val), 64'(0));
    chk("cancel_lvl", 64'(a_lvl), 64'(0));
    pat = 8'h96;
    for (int i = 0; i < DW; i++) drive(1'b1, pat[i], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clean_word", 64'(a_data), 64'(8'h96));
    chk("clean_nb",   64'(a_nbits), 64'(8));

    // Reset mid-word with overflow set, then a lone eop in IDLE.
    send_rand_words(5, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_data", 64'(a_data), 64'(0));
    chk("rst_ovf",  64'(a_ovf),  64'(0));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("eop_idle_lvl", 64'(a_lvl), 64'(0));
    chk("eop_idle_val", 64'(a_val), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 11) == 0,
            $urandom_range(0, 79) == 0, 1'($urandom), $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_fifo_deser.md
SIPO_FIFO_DESER -- requirements
Module: sipo_fifo_deser

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the parallel word width in bits (legal range 2..64).
REQ-002 Parameter DEPTH, default 4, SHALL set the output FIFO depth in words (power of two, at least 2).
REQ-003 Parameter LSB_FIRST, default 1, SHALL select bit order: 1 means the first received bit lands in word bit 0, 0 means it lands in word bit DATA_WIDTH-1.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 s_data_in  input  1  SHALL carry the serial data bit, sampled only when s_data_in_val=1.
REQ-007 s_data_in_val  input  1  SHALL qualify s_data_in.
REQ-008 s_eop  input  1  SHALL mark end of packet and flush any partial word.
REQ-009 sipo_cancel  input  1  SHALL abort the packet and clear all state.
REQ-010 p_data_out  output  DATA_WIDTH  SHALL carry the FIFO head word.
REQ-011 p_data_out_val  output  1  SHALL be high while the FIFO is non-empty.
REQ-012 p_data_out_rdy  input  1  SHALL, with val, pop the head word.
REQ-013 p_data_out_last  output  1  SHALL flag the final word of a packet.
REQ-014 p_data_out_nbits  output  $clog2(DATA_WIDTH+1)  SHALL give the count of valid bits in the head word.
REQ-015 overflow  output  1  SHALL be a sticky word-dropped flag.
REQ-016 fifo_level  output  $clog2(DEPTH+1)  SHALL give the current FIFO occupancy.

Function
REQ-017 Assembler FSM SHALL have two states: IDLE (0 bits pending) and ACCUM (1..DATA_WIDTH-1 bits pending).
REQ-018 Each valid bit SHALL be written by index into the accumulating word: position k (LSB_FIRST=1) or DATA_WIDTH-1-k (LSB_FIRST=0), where k is the bit count before the write.
REQ-019 Unreceived bit positions SHALL read 0, so partial words are right-justified (LSB_FIRST=1) or left-justified (LSB_FIRST=0).
REQ-020 On the cycle that supplies bit DATA_WIDTH-1, the complete word SHALL be pushed with nbits=DATA_WIDTH, last=s_eop, and the FSM SHALL go to IDLE.
REQ-021 p_data_out_val SHALL rise on the cycle after that push; this is the minimum latency.
REQ-022 Back-to-back words SHALL be accepted with no bubble: bit 0 of the next word may arrive on the cycle after the push.
REQ-023 s_eop in ACCUM, with or without a valid bit that cycle, SHALL push the partial word with last=1 and nbits equal to the bits held including that cycle's bit, then go to IDLE.
REQ-024 s_eop in IDLE with s_data_in_val=1 SHALL push a 1-bit word with last=1.
REQ-025 s_eop in IDLE with s_data_in_val=0 SHALL push nothing and have no effect.
REQ-026 A cycle with s_data_in_val=0 and s_eop=0 SHALL hold all assembler state; pending bits SHALL NOT be discarded.
REQ-027 The FIFO SHALL be show-ahead: p_data_out, p_data_out_last and p_data_out_nbits SHALL be valid whenever val=1.
REQ-028 A pop SHALL occur exactly when val and rdy are both high; outputs SHALL stay stable while val=1 and rdy=0.
REQ-029 A push into a full FIFO with no pop that cycle SHALL drop the word and set overflow; overflow SHALL hold until rst or sipo_cancel.
REQ-030 A simultaneous push and pop on a full FIFO SHALL succeed with no overflow and fifo_level unchanged.
REQ-031 A simultaneous push and pop on an empty FIFO SHALL push only; val rises on the next cycle.
REQ-032 sipo_cancel SHALL take priority over all inputs and within one cycle clear the FIFO, assembler, FSM (to IDLE) and overflow; bits presented that cycle SHALL be discarded.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH; fifo_level SHALL range from 0 to DEPTH.

Reset
REQ-034 rst SHALL take priority over sipo_cancel and all other inputs.
REQ-035 On rst the outputs SHALL be: p_data_out=0, p_data_out_val=0, p_data_out_last=0, p_data_out_nbits=0, overflow=0, fifo_level=0.
REQ-036 On rst the FSM SHALL go to IDLE and the bit count SHALL be 0.
REQ-037 rst asserted mid-word or mid-packet SHALL discard all pending and queued data, with outputs as in REQ-035 on the next cycle.

Structure
REQ-038 FSM state encodings and the width helpers ($clog2-based count and level widths) SHALL live in the shared usb_hub_pkg package.
REQ-039 Storage SHALL be one sub-module, sync_fifo (parameters WIDTH = DATA_WIDTH + nbits width + 1, DEPTH); the assembler and FSM SHALL stay in the top module.

Verification
REQ-040 LSB_FIRST=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles, rdy=1 -> one word 0x4D, nbits=8, last=0, val high one cycle after the 8th bit.
REQ-041 LSB_FIRST=0: same bits -> 0xB2; then 3 bits 1,1,0 with s_eop on the 3rd bit -> 0xC0, nbits=3, last=1.
REQ-042 DEPTH=4, rdy=0, 5 full words -> fifo_level=4, overflow=1, 5th word absent; drain gives words 1-4 in order.
REQ-043 FIFO full, rdy=1 on the cycle word 5 completes -> no overflow, fifo_level stays 4, word 5 is read last.
REQ-044 4 bits pending plus 2 queued words, sipo_cancel pulsed -> next cycle val=0, fifo_level=0, overflow=0; the next 8 bits form a clean word.
REQ-045 rst asserted mid-word with overflow=1 -> all outputs 0 on the next cycle; s_eop alone in IDLE -> no push.
